seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver that consumes the packed BCD digits produced by the chained BCD up/down digit counters and drives a common-anode multi-digit display. It scans one digit position per refresh slot and samples a coherent snapshot of all digits once per frame, so a carry rippling through the counter chain never tears the display. It also performs leading-zero blanking and decimal-point insertion, and sits between the counter chain and the board's anode/cathode pins.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_decoder.sv | 20 ++
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path.
//   SEG_0..SEG_9 : active-low cathode patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments dark
//   SEG_DASH     : centre bar only, shown for non-decimal codes 10..15
//   bcd_to_seg() : BCD digit -> active-low cathode pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Purely combinational digit decoder.
//   bcd   in  4  digit value (10..15 render as a dash)
//   blank in  1  1 = leading-zero blanked, all segments dark
//   seg   out 7  active-low cathodes {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a common-anode multi-digit display. One digit
// position is lit per refresh slot; the packed BCD inputs are captured once
// per frame so a carry rippling through the upstream counter chain can never
// show a half-updated number.
//
// Parameters
//   NUM_DIGITS  display positions (2..8)
//   REFRESH_DIV clk cycles per digit slot (>= 2)
//   BLANK_LZ    1 = blank leading zeros, 0 = always show every digit
// Ports
//   clk         in  1             system clock
//   rst         in  1             synchronous, active-high reset
//   en          in  1             scan enable; low blanks display, freezes scan
//   bcd_in      in  4*NUM_DIGITS  packed digits, [3:0] = digit 0 (rightmost)
//   dp_in       in  NUM_DIGITS    decimal-point request per digit, 1 = lit
//   an          out NUM_DIGITS    anode select, active-low, one-hot-low
//   seg         out 7             cathodes {g,f,e,d,c,b,a}, active-low
//   dp          out 1             decimal-point cathode, active-low
//   frame_start out 1             one-cycle pulse on the first slot of a frame
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int PCNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PCNT_W-1:0]       pcnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    // Set by the frame wrap, consumed by the first enabled cycle after it, so
    // frame_start lands on the first cycle that actually lights digit 0.
    logic                    frame_pending;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_run;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              dec_seg;

    assign tick = en && (pcnt == PCNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Walk down from the most significant position; a position stays blank
    // only while every digit at or above it is zero with no decimal point.
    // Digit 0 is excluded so a zero value still shows a single "0".
    // NOTE: every variable written in always_comb is given a value before any
    // conditional path, otherwise synthesis infers a latch.
    always_comb begin
        blank_mask = '0;
        lz_run     = (BLANK_LZ != 0);
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run        = lz_run && (shadow_bcd[4*i +: 4] == 4'd0) && !shadow_dp[i];
            blank_mask[i] = lz_run;
        end
    end

    // Select the active position's data and build the anode pattern.
    always_comb begin
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_bcd   = shadow_bcd[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = blank_mask[i];
                an_next[i] = !en;
            end
        end
    end

    seg7_decoder u_decoder (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt          <= '0;
            idx           <= '0;
            shadow_bcd    <= '0;
            shadow_dp     <= '0;
            frame_pending <= 1'b0;
            an            <= '1;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            if (en) begin
                if (tick) begin
                    pcnt <= '0;
                    idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end else begin
                    pcnt <= pcnt + PCNT_W'(1);
                end
            end

            // Capture a coherent copy of all digits only at the frame boundary.
            if (wrap) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end

            if (wrap) begin
                frame_pending <= 1'b1;
            end else if (en) begin
                frame_pending <= 1'b0;
            end

            an          <= an_next;
            seg         <= en ? dec_seg : SEG_BLANK;
            dp          <= en ? ~cur_dp : 1'b1;
            frame_start <= en && frame_pending;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Two instances share all inputs: dut (BLANK_LZ=1) and dut_nb (BLANK_LZ=0).
// Whole-frame display patterns come from a vector table; reset, tear-free
// snapshot, enable freeze and mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  an,  an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp,  dp_nb;
    logic        fs,  fs_nb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk (clk), .rst (rst), .en (en), .bcd_in (bcd_in), .dp_in (dp_in),
        .an (an), .seg (seg), .dp (dp), .frame_start (fs)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk (clk), .rst (rst), .en (en), .bcd_in (bcd_in), .dp_in (dp_in),
        .an (an_nb), .seg (seg_nb), .dp (dp_nb), .frame_start (fs_nb)
    );

    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dpi;
        logic [3:0][6:0] seg;     // expected per position, BLANK_LZ=1
        logic [3:0]      dpo;     // expected dp pin per position
        logic [3:0][6:0] seg_nb;  // expected per position, BLANK_LZ=0
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!fs && n < 64);
        check("wait_frame_start", fs, 1'b1);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int n = 0;
        while (an !== target && n < 20) begin
            step();
            n++;
        end
        check(name, an, target);
    endtask

    // Assumes the current cycle is the first cycle of slot 'first'; checks
    // every remaining cycle of the frame.
    task automatic check_frame(input logic [3:0][6:0] es, input logic [3:0] edp,
                               input logic [3:0][6:0] enb, input int first,
                               input string name);
        logic [3:0] exp_an;
        for (int s = first; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(s == first && c == 0)) step();
                exp_an = ~(4'b0001 << s);
                check($sformatf("%s s%0d c%0d an", name, s, c), an, exp_an);
                check($sformatf("%s s%0d c%0d seg", name, s, c), seg, es[s]);
                check($sformatf("%s s%0d c%0d dp", name, s, c), dp, edp[s]);
                check($sformatf("%s s%0d c%0d seg_nb", name, s, c), seg_nb, enb[s]);
                check($sformatf("%s s%0d c%0d frame_start", name, s, c), fs,
                      (s == 0 && c == 0) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{bcd: 16'h1234, dpi: 4'b0000,
                    seg: {7'h79, 7'h24, 7'h30, 7'h19}, dpo: 4'b1111,
                    seg_nb: {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{bcd: 16'h0070, dpi: 4'b0000,
                    seg: {7'h7F, 7'h7F, 7'h78, 7'h40}, dpo: 4'b1111,
                    seg_nb: {7'h40, 7'h40, 7'h78, 7'h40}};
        vecs[2] = '{bcd: 16'h0005, dpi: 4'b0010,
                    seg: {7'h7F, 7'h7F, 7'h40, 7'h12}, dpo: 4'b1101,
                    seg_nb: {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[3] = '{bcd: 16'h0A08, dpi: 4'b0000,
                    seg: {7'h7F, 7'h3F, 7'h40, 7'h00}, dpo: 4'b1111,
                    seg_nb: {7'h40, 7'h3F, 7'h40, 7'h00}};
        vecs[4] = '{bcd: 16'h0000, dpi: 4'b1000,
                    seg: {7'h40, 7'h40, 7'h40, 7'h40}, dpo: 4'b0111,
                    seg_nb: {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{bcd: 16'h9865, dpi: 4'b0000,
                    seg: {7'h10, 7'h00, 7'h02, 7'h12}, dpo: 4'b1111,
                    seg_nb: {7'h10, 7'h00, 7'h02, 7'h12}};
        vecs[6] = '{bcd: 16'h0000, dpi: 4'b0000,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dpo: 4'b1111,
                    seg_nb: {7'h40, 7'h40, 7'h40, 7'h40}};

        // Reset held for three cycles with en=1.
        rst    = 1'b1;
        en     = 1'b1;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        repeat (3) step();
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);
        check("reset frame_start", fs, 1'b0);
        rst = 1'b0;

        // Before the first snapshot: "0" on digit 0, idx advances at edge 4.
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 4) begin
                check($sformatf("post_reset k%0d an", k), an, 4'b1110);
                check($sformatf("post_reset k%0d seg", k), seg, 7'h40);
            end else begin
                check("post_reset k5 an", an, 4'b1101);
                check("post_reset k5 seg", seg, 7'h7F);
            end
            check($sformatf("post_reset k%0d dp", k), dp, 1'b1);
            check($sformatf("post_reset k%0d frame_start", k), fs, 1'b0);
        end
        wait_frame(n);
        check("first frame_start edge", 5 + n, 17);
        check_frame(vecs[0].seg, vecs[0].dpo, vecs[0].seg_nb, 0, "scan_1234");

        // Table-driven whole-frame patterns.
        for (int v = 0; v < 7; v++) begin
            wait_frame(n);
            bcd_in = vecs[v].bcd;
            dp_in  = vecs[v].dpi;
            wait_frame(n);
            check($sformatf("vec%0d frame period", v), n, 16);
            check_frame(vecs[v].seg, vecs[v].dpo, vecs[v].seg_nb, 0,
                        $sformatf("vec%0d", v));
        end

        // Tear-free snapshot: input changes mid-frame are not shown until the
        // next frame.
        wait_frame(n);
        bcd_in = 16'h0999;
        dp_in  = 4'b0000;
        wait_frame(n);
        wait_an(4'b1101, "tear reach idx1");
        bcd_in = 16'h1000;
        check_frame({7'h7F, 7'h10, 7'h10, 7'h10}, 4'b1111,
                    {7'h40, 7'h10, 7'h10, 7'h10}, 1, "tear_old");
        step();
        check_frame({7'h79, 7'h40, 7'h40, 7'h40}, 4'b1111,
                    {7'h79, 7'h40, 7'h40, 7'h40}, 0, "tear_new");

        // Enable freeze at idx=2, with dash codes on digits 2 and 3.
        wait_frame(n);
        bcd_in = 16'hFA21;
        wait_frame(n);
        wait_an(4'b1011, "en reach idx2");
        check("en dash A seg", seg, 7'h3F);
        step();
        check("en second cycle an", an, 4'b1011);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("en_off k%0d an", k), an, 4'hF);
            check($sformatf("en_off k%0d seg", k), seg, 7'h7F);
            check($sformatf("en_off k%0d dp", k), dp, 1'b1);
            check($sformatf("en_off k%0d frame_start", k), fs, 1'b0);
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("resume idx2 k%0d an", k), an, 4'b1011);
            check($sformatf("resume idx2 k%0d seg", k), seg, 7'h3F);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("resume idx3 k%0d an", k), an, 4'b0111);
            check($sformatf("resume idx3 k%0d seg", k), seg, 7'h3F);
            check($sformatf("resume idx3 k%0d frame_start", k), fs, 1'b0);
        end
        step();
        check("resume wrap frame_start", fs, 1'b1);
        check("resume wrap an", an, 4'b1110);
        check("resume wrap seg", seg, 7'h79);

        // Reset in mid-frame overrides en and clears the shadow.
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midreset an", an, 4'hF);
        check("midreset seg", seg, 7'h7F);
        check("midreset seg_nb", seg_nb, 7'h7F);
        check("midreset dp", dp, 1'b1);
        check("midreset frame_start", fs, 1'b0);
        rst = 1'b0;
        step();
        check("midreset release an", an, 4'b1110);
        check("midreset release seg", seg, 7'h40);
        check("midreset release frame_start", fs, 1'b0);
        wait_frame(n);
        check("midreset first frame_start edge", 1 + n, 17);
        check("midreset new frame seg", seg, 7'h79);
        check("midreset new frame an", an, 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
